// File: rtl/aurora_rx_post.sv
`default_nettype none
// ============================================================================
// Module   : aurora_rx_post
// Brief    : Aurora RX post-processor: frame statistics, optional trailing
//            sequence-word strip/check, egress FIFO with registered output.
// Revision : 1.0 - initial release
// ============================================================================
module aurora_rx_post #(
  parameter int DATA_WIDTH = 32,
  parameter int SEQ_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNTR_WIDTH = 64
) (
  input  logic                        m_axis_aclk,
  input  logic                        m_axis_areset,
  input  logic                        s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic                        ctrl_strip_seq_en,
  input  logic                        ctrl_seq_chk_en,
  input  logic                        ctrl_rst_cntr,
  output logic [CNTR_WIDTH-1:0]       stat_frames_in,
  output logic [CNTR_WIDTH-1:0]       stat_frames_out,
  output logic [CNTR_WIDTH-1:0]       stat_seq_err,
  output logic [CNTR_WIDTH-1:0]       stat_drop,
  output logic                        stat_overflow,
  output logic [$clog2(FIFO_DEPTH):0] stat_fifo_level
);

  localparam int                    c_AW       = $clog2(FIFO_DEPTH);
  localparam int                    c_LW       = c_AW + 1;
  localparam logic [c_LW-1:0]       c_DEPTH    = c_LW'(FIFO_DEPTH);
  localparam logic [CNTR_WIDTH-1:0] c_CNT_ONE  = CNTR_WIDTH'(1);
  localparam logic [SEQ_WIDTH-1:0]  c_SEQ_ONE  = SEQ_WIDTH'(1);

  // ---------------------------------------------------------------- mode latch
  logic r_in_frame;
  logic r_mode;
  logic w_mode;

  // The control input only takes effect between frames
  assign w_mode = r_in_frame ? r_mode : ctrl_strip_seq_en;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      r_in_frame <= 1'b0;
      r_mode     <= 1'b0;
    end else begin
      r_mode <= w_mode;
      if (s_axis_tvalid) begin
        r_in_frame <= ~s_axis_tlast;
      end
    end
  end

  // ------------------------------------------------------- hold register / push
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_vld;
  logic                  w_push_req;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_push_last;

  // In strip mode the held word goes out with the current beat's tlast, so the
  // word before the sequence word carries the frame end.
  always_comb begin
    w_push_req  = 1'b0;
    w_push_data = s_axis_tdata;
    w_push_last = s_axis_tlast;
    if (s_axis_tvalid) begin
      if (!w_mode) begin
        w_push_req = 1'b1;
      end else begin
        w_push_req  = r_hold_vld;
        w_push_data = r_hold_data;
      end
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else if (s_axis_tvalid && w_mode) begin
      r_hold_vld <= ~s_axis_tlast;
      if (!s_axis_tlast) begin
        r_hold_data <= s_axis_tdata;
      end
    end
  end

  // ------------------------------------------------------------ sequence check
  logic [SEQ_WIDTH-1:0] r_exp;
  logic                 r_exp_vld;
  logic [SEQ_WIDTH-1:0] w_seq;
  logic                 w_chk;
  logic                 w_seq_err;
  logic                 w_leave_strip;

  assign w_seq         = s_axis_tdata[SEQ_WIDTH-1:0];
  assign w_chk         = s_axis_tvalid & s_axis_tlast & w_mode & ctrl_seq_chk_en;
  assign w_seq_err     = w_chk & r_exp_vld & (w_seq != r_exp);
  assign w_leave_strip = r_mode & ~w_mode;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      r_exp_vld <= 1'b0;
      r_exp     <= '0;
    end else if (ctrl_rst_cntr || w_leave_strip) begin
      r_exp_vld <= 1'b0;
    end else if (w_chk) begin
      r_exp_vld <= 1'b1;
      r_exp     <= w_seq + c_SEQ_ONE;
    end
  end

  // -------------------------------------------------------------- egress FIFO
  // r_count includes the entry currently presented in the output register.
  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_LW-1:0]       r_count;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drop;
  logic [c_AW-1:0]       w_rd_next;
  logic [c_LW-1:0]       w_cnt_after_pop;

  assign w_pop           = r_out_vld & m_axis_tready;
  assign w_full          = (r_count == c_DEPTH);
  assign w_push          = w_push_req & (~w_full | w_pop);
  assign w_drop          = w_push_req & w_full & ~w_pop;
  assign w_rd_next       = r_rd_ptr + c_AW'(w_pop);
  assign w_cnt_after_pop = r_count - c_LW'(w_pop);

  always_ff @(posedge m_axis_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_push_last, w_push_data};
    end
  end

  // A word written this cycle is not yet counted, so it reaches the output
  // register no earlier than the next cycle.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_after_pop + c_LW'(w_push);
      if (!r_out_vld || w_pop) begin
        r_out_vld <= (w_cnt_after_pop != '0);
        if (w_cnt_after_pop != '0) begin
          {r_out_last, r_out_data} <= r_mem[w_rd_next];
        end
      end
    end
  end

  assign m_axis_tvalid   = r_out_vld;
  assign m_axis_tdata    = r_out_data;
  assign m_axis_tlast    = r_out_last;
  assign stat_fifo_level = r_count;

  // --------------------------------------------------------------- statistics
  logic [CNTR_WIDTH-1:0] r_frames_in;
  logic [CNTR_WIDTH-1:0] r_frames_out;
  logic [CNTR_WIDTH-1:0] r_seq_err;
  logic [CNTR_WIDTH-1:0] r_drop;
  logic                  r_overflow;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset || ctrl_rst_cntr) begin
      r_frames_in  <= '0;
      r_frames_out <= '0;
      r_seq_err    <= '0;
      r_drop       <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tlast) begin
        r_frames_in <= r_frames_in + c_CNT_ONE;
      end
      if (w_pop && r_out_last) begin
        r_frames_out <= r_frames_out + c_CNT_ONE;
      end
      if (w_seq_err) begin
        r_seq_err <= r_seq_err + c_CNT_ONE;
      end
      if (w_drop) begin
        r_drop     <= r_drop + c_CNT_ONE;
        r_overflow <= 1'b1;
      end
    end
  end

  assign stat_frames_in  = r_frames_in;
  assign stat_frames_out = r_frames_out;
  assign stat_seq_err    = r_seq_err;
  assign stat_drop       = r_drop;
  assign stat_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_aurora_rx_post.sv
`default_nettype none
// ============================================================================
// Module   : tb_aurora_rx_post
// Brief    : Directed and randomized bench for aurora_rx_post against a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aurora_rx_post;

  localparam int DW = 32;
  localparam int SW = 32;
  localparam int FD = 16;
  localparam int CW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          s_vld;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_rdy;
  logic          strip;
  logic          chk_en;
  logic          rst_cntr;
  logic          m_vld;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] st_fin, st_fout, st_serr, st_drop;
  logic          st_ovf;
  logic [$clog2(FD):0] st_lvl;

  aurora_rx_post #(
    .DATA_WIDTH(DW), .SEQ_WIDTH(SW), .FIFO_DEPTH(FD), .CNTR_WIDTH(CW)
  ) u_dut (
    .m_axis_aclk       (clk),
    .m_axis_areset     (rst),
    .s_axis_tvalid     (s_vld),
    .s_axis_tdata      (s_data),
    .s_axis_tlast      (s_last),
    .m_axis_tvalid     (m_vld),
    .m_axis_tready     (m_rdy),
    .m_axis_tdata      (m_data),
    .m_axis_tlast      (m_last),
    .ctrl_strip_seq_en (strip),
    .ctrl_seq_chk_en   (chk_en),
    .ctrl_rst_cntr     (rst_cntr),
    .stat_frames_in    (st_fin),
    .stat_frames_out   (st_fout),
    .stat_seq_err      (st_serr),
    .stat_drop         (st_drop),
    .stat_overflow     (st_ovf),
    .stat_fifo_level   (st_lvl)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: FIFO contents as a queue of words stamped with their push edge.
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            t;
  } ent_t;

  ent_t          q[$];
  int            k = 0;
  bit            m_in_frame, m_mode, h_vld, e_vld, ovf;
  logic [DW-1:0] h_d;
  logic [SW-1:0] e;
  logic [63:0]   f_in, f_out, s_err, drp;

  // A word pushed at edge p is first accepted at edge p+2.
  function automatic bit mvalid();
    return (q.size() > 0) && (q[0].t <= k - 2);
  endfunction

  task automatic model_step();
    bit            pop, eff, leave, preq, pl;
    logic [DW-1:0] pd;
    logic [SW-1:0] s;
    if (rst) begin
      q.delete();
      m_in_frame = 0; m_mode = 0; h_vld = 0; e_vld = 0; ovf = 0;
      f_in = 0; f_out = 0; s_err = 0; drp = 0;
    end else begin
      pop = m_rdy && mvalid();
      if (pop) begin
        if (q[0].l) f_out = f_out + 1;
        q.delete(0);
      end
      eff    = m_in_frame ? m_mode : strip;
      leave  = m_mode && !eff;
      m_mode = eff;
      preq   = 0;
      pd     = s_data;
      pl     = s_last;
      if (s_vld) begin
        if (!eff) begin
          preq = 1;
        end else begin
          if (h_vld) begin preq = 1; pd = h_d; end
          if (s_last) h_vld = 0;
          else begin h_vld = 1; h_d = s_data; end
          if (s_last && chk_en) begin
            s = s_data[SW-1:0];
            if (e_vld && s != e) s_err = s_err + 1;
            e     = s + 1;
            e_vld = 1;
          end
        end
        if (s_last) f_in = f_in + 1;
        m_in_frame = !s_last;
      end
      if (preq) begin
        if (q.size() == FD) begin drp = drp + 1; ovf = 1; end
        else q.push_back('{d: pd, l: pl, t: k});
      end
      if (leave || rst_cntr) e_vld = 0;
      if (rst_cntr) begin
        f_in = 0; f_out = 0; s_err = 0; drp = 0; ovf = 0;
      end
    end
    k++;
  endtask

  task automatic compare();
    bit v;
    v = mvalid();
    check("tvalid", m_vld, v);
    if (v) begin
      check("tdata", m_data, q[0].d);
      check("tlast", m_last, q[0].l);
    end
    check("fifo_level", st_lvl, q.size());
    check("frames_in", st_fin, f_in);
    check("frames_out", st_fout, f_out);
    check("seq_err", st_serr, s_err);
    check("drop", st_drop, drp);
    check("overflow", st_ovf, ovf);
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l);
    s_vld = v; s_data = d; s_last = l;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0);
  endtask

  initial begin
    rst = 1; s_vld = 0; s_data = '0; s_last = 0; m_rdy = 1;
    strip = 0; chk_en = 0; rst_cntr = 0;
    idle(2);
    rst = 0;
    check("rst_tdata", m_data, 0);
    check("rst_tlast", m_last, 0);
    check("rst_level", st_lvl, 0);

    // Pass-through frame A,B,C,D
    cycle(1, 32'hA, 0); cycle(1, 32'hB, 0); cycle(1, 32'hC, 0); cycle(1, 32'hD, 1);
    idle(4);
    check("pt_frames_in", st_fin, 1);
    check("pt_frames_out", st_fout, 1);

    // Strip with check: {1,2,3,seq5} {4,5,6,seq6}
    strip = 1; chk_en = 1;
    idle(1);
    cycle(1, 1, 0); cycle(1, 2, 0); cycle(1, 3, 0); cycle(1, 5, 1);
    cycle(1, 4, 0); cycle(1, 5, 0); cycle(1, 6, 0); cycle(1, 6, 1);
    idle(4);
    check("strip_frames_out", st_fout, 3);
    check("strip_seq_err", st_serr, 0);

    // Sequence 7, 9, 10 -> one error
    cycle(1, 32'h11, 0); cycle(1, 7, 1);
    cycle(1, 32'h12, 0); cycle(1, 9, 1);
    cycle(1, 32'h13, 0); cycle(1, 10, 1);
    idle(3);
    check("seq_gap_err", st_serr, 1);

    // Counter clear invalidates expectation; wrap FFFFFFFF -> 0 is clean
    rst_cntr = 1; idle(1); rst_cntr = 0;
    cycle(1, 32'hFFFF_FFFF, 1);
    cycle(1, 32'h21, 0); cycle(1, 0, 1);
    idle(3);
    check("wrap_seq_err", st_serr, 0);
    check("wrap_frames_in", st_fin, 2);
    check("wrap_frames_out", st_fout, 1);

    // Single-beat strip frame
    cycle(1, 1, 1);
    idle(3);
    check("single_frames_in", st_fin, 3);
    check("single_frames_out", st_fout, 1);
    check("single_seq_err", st_serr, 0);

    // Overflow: 20-word pass-through frame into a stalled FIFO
    strip = 0; m_rdy = 0;
    idle(1);
    for (int i = 0; i < 20; i++) cycle(1, 32'h100 + i, (i == 19));
    check("ovf_level", st_lvl, 16);
    check("ovf_drop", st_drop, 4);
    check("ovf_sticky", st_ovf, 1);
    m_rdy = 1;
    idle(20);
    check("ovf_drained", st_lvl, 0);
    check("ovf_frames_out", st_fout, 1);

    // Mode toggled mid-frame: this frame stays pass-through, next one strips
    cycle(1, 32'hA0, 0);
    strip = 1;
    cycle(1, 32'hA1, 0); cycle(1, 32'hA2, 0); cycle(1, 32'hA3, 1);
    cycle(1, 32'hB0, 0); cycle(1, 32'hB1, 0); cycle(1, 32'h77, 1);
    idle(4);
    check("toggle_frames_out", st_fout, 3);

    // Counter clear coincident with a last beat
    cycle(1, 32'hC0, 0);
    rst_cntr = 1;
    cycle(1, 32'hC1, 1);
    rst_cntr = 0;
    check("rc_frames_in", st_fin, 0);
    check("rc_frames_out", st_fout, 0);
    check("rc_drop", st_drop, 0);
    check("rc_overflow", st_ovf, 0);
    idle(4);

    // Reset mid-frame
    strip = 0;
    cycle(1, 32'hD0, 0); cycle(1, 32'hD1, 0);
    rst = 1; idle(1); rst = 0;
    check("mid_rst_tvalid", m_vld, 0);
    check("mid_rst_tdata", m_data, 0);
    check("mid_rst_level", st_lvl, 0);
    cycle(1, 32'hE0, 0); cycle(1, 32'hE1, 1);
    idle(4);
    check("mid_rst_frames_out", st_fout, 1);

    // Randomized traffic
    for (int blk = 0; blk < 30; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(9, 2);
      for (int i = 0; i < 100; i++) begin
        bit            v, l;
        logic [DW-1:0] d;
        m_rdy = ($urandom_range(9) < rdy_pct);
        if ($urandom_range(19) == 0) strip = ~strip;
        if ($urandom_range(29) == 0) chk_en = ~chk_en;
        rst_cntr = ($urandom_range(99) == 0);
        v = ($urandom_range(9) < 7);
        l = ($urandom_range(3) == 0);
        d = $urandom;
        if (l && $urandom_range(1) == 1) d = e;
        cycle(v, d, l);
      end
    end
    rst_cntr = 0; m_rdy = 1;
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
